// File: rtl/hsi_rx_sequencer_if.sv
// Token-input / word-output bundle between the HSI tokenizer, the rx sequencer and the readout consumer.
// master: sequencer side; slave: tokenizer/consumer side.
interface hsi_rx_sequencer_if;
    logic        tok_valid;
    logic [31:0] tok_data;
    logic        tok_clr;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    modport master (
        input  tok_valid, tok_data, m_ready,
        output tok_clr, m_data, m_valid
    );

    modport slave (
        output tok_valid, tok_data, m_ready,
        input  tok_clr, m_data, m_valid
    );
endinterface

// File: rtl/hsi_rx_sequencer.sv
// HSI gyro receive sequencer: frames tokenizer words into a FIFO, with a watchdog and sticky status flags.
// Define HSI_RX_SEQ_CHECKSUM_EN to expect a trailing XOR checksum word after each frame.
module hsi_rx_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8,
    parameter int TO_W       = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LEN_W-1:0]       frame_len,
    input  logic [TO_W-1:0]        timeout_cycles,
    hsi_rx_sequencer_if.master     bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic [LEN_W-1:0]       words_rcvd,
    output logic                   overflow,
    output logic                   timeout_err,
    output logic                   chk_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;

    state_t          state, state_next;
    logic [31:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic [LEN_W-1:0] len_q;
    logic [TO_W-1:0] wd;
    logic [TO_W:0]   wd_inc;
    logic fifo_full, fifo_empty;
    logic push, push_ok, pop;
    logic tok_fire, data_tok, chk_tok, last_data, end_tok;
    logic wd_expire, start_ok;

`ifdef HSI_RX_SEQ_CHECKSUM_EN
    logic        chk_phase;
    logic [31:0] xor_acc;
    logic        chk_err_q;
`endif

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == (AW+1)'(FIFO_DEPTH));
    assign bus.m_valid = !fifo_empty;
    assign bus.m_data  = fifo_empty ? '0 : mem[rd_ptr];
    assign bus.tok_clr = (state != RECV);
    assign busy        = (state != IDLE);
    assign frame_done  = (state == DONE);

    // Token classification, FIFO handshake and watchdog expiry
    always_comb begin
        tok_fire = (state == RECV) && bus.tok_valid;
`ifdef HSI_RX_SEQ_CHECKSUM_EN
        data_tok = tok_fire && !chk_phase;
        chk_tok  = tok_fire && chk_phase;
`else
        data_tok = tok_fire;
        chk_tok  = 1'b0;
`endif
        last_data = data_tok && ((words_rcvd + LEN_W'(1)) == len_q);
`ifdef HSI_RX_SEQ_CHECKSUM_EN
        end_tok = chk_tok;
`else
        end_tok = last_data;
`endif
        push      = data_tok;
        pop       = !fifo_empty && bus.m_ready;
        push_ok   = push && (!fifo_full || pop) && !abort;
        start_ok  = (state == IDLE) && start && !abort && (frame_len != '0);
        wd_inc    = (TO_W+1)'(wd) + (TO_W+1)'(1);
        wd_expire = (state == RECV) && !bus.tok_valid && (timeout_cycles != '0) &&
                    (wd_inc >= (TO_W+1)'(timeout_cycles));
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_next = RECV;
                RECV:    if (wd_expire || end_tok) state_next = FLUSH;
                FLUSH:   if (fifo_empty) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // When full, wr_ptr == rd_ptr: a simultaneous pop has already presented the old word, so overwriting is safe
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= bus.tok_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            len_q       <= '0;
            words_rcvd  <= '0;
            wd          <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else if (abort) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + (AW+1)'(1);
            else if (!push_ok && pop) count <= count - (AW+1)'(1);
            if (push && fifo_full && !pop) overflow <= 1'b1;
            if (state == RECV) begin
                if (bus.tok_valid) wd <= '0;
                else if ((wd != timeout_cycles) && (wd != '1)) wd <= wd + TO_W'(1);
            end
            if (data_tok)  words_rcvd  <= words_rcvd + LEN_W'(1);
            if (wd_expire) timeout_err <= 1'b1;
            if (start_ok) begin
                len_q       <= frame_len;
                words_rcvd  <= '0;
                wd          <= '0;
                overflow    <= 1'b0;
                timeout_err <= 1'b0;
            end
        end
    end

`ifdef HSI_RX_SEQ_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            chk_phase <= 1'b0;
            xor_acc   <= '0;
            chk_err_q <= 1'b0;
        end else if (!abort) begin
            if (start_ok) begin
                chk_phase <= 1'b0;
                xor_acc   <= '0;
                chk_err_q <= 1'b0;
            end else begin
                if (data_tok) begin
                    xor_acc <= xor_acc ^ bus.tok_data;
                    if (last_data) chk_phase <= 1'b1;
                end
                if (chk_tok) begin
                    chk_phase <= 1'b0;
                    if (bus.tok_data != xor_acc) chk_err_q <= 1'b1;
                end
            end
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_hsi_rx_sequencer.sv
// Directed self-checking bench for hsi_rx_sequencer; checksum-frame cases run when HSI_RX_SEQ_CHECKSUM_EN is defined.
module tb_hsi_rx_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  frame_len;
    logic [15:0] timeout_cycles;
    logic        busy;
    logic        frame_done;
    logic [7:0]  words_rcvd;
    logic        overflow;
    logic        timeout_err;
    logic        chk_err;
    int          checks;
    int          errors;

    hsi_rx_sequencer_if bus_if ();

    hsi_rx_sequencer #(
        .FIFO_DEPTH(4),
        .LEN_W(8),
        .TO_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .abort(abort),
        .frame_len(frame_len),
        .timeout_cycles(timeout_cycles),
        .bus(bus_if),
        .busy(busy),
        .frame_done(frame_done),
        .words_rcvd(words_rcvd),
        .overflow(overflow),
        .timeout_err(timeout_err),
        .chk_err(chk_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle of start/abort/token, then release the pulses
    task automatic apply_stimulus(input logic st, input logic ab, input logic tv, input logic [31:0] td);
        start            = st;
        abort            = ab;
        bus_if.tok_valid = tv;
        bus_if.tok_data  = td;
        step();
        start            = 1'b0;
        abort            = 1'b0;
        bus_if.tok_valid = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        start            = 1'b0;
        abort            = 1'b0;
        frame_len        = '0;
        timeout_cycles   = '0;
        bus_if.tok_valid = 1'b0;
        bus_if.tok_data  = '0;
        bus_if.m_ready   = 1'b0;
        step();
        step();
        reset = 1'b0;

        $display("[TB] reset state");
        check_output("rst_tok_clr", 32'(bus_if.tok_clr), 32'd1);
        check_output("rst_m_valid", 32'(bus_if.m_valid), 32'd0);
        check_output("rst_m_data", bus_if.m_data, 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_frame_done", 32'(frame_done), 32'd0);
        check_output("rst_words", 32'(words_rcvd), 32'd0);
        check_output("rst_flags", {29'd0, overflow, timeout_err, chk_err}, 32'd0);

`ifdef HSI_RX_SEQ_CHECKSUM_EN
        $display("[TB] checksum frames");
        frame_len      = 8'd2;
        timeout_cycles = 16'd100;
        bus_if.m_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000FFFF);
        check_output("ck1_d0", bus_if.m_data, 32'h0000FFFF);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF0000);
        check_output("ck1_d1", bus_if.m_data, 32'hFFFF0000);
        check_output("ck1_wait_sum", 32'(bus_if.tok_clr), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
        check_output("ck1_flush", 32'(bus_if.tok_clr), 32'd1);
        check_output("ck1_words", 32'(words_rcvd), 32'd2);
        check_output("ck1_m_valid", 32'(bus_if.m_valid), 32'd0);
        step();
        check_output("ck1_done", 32'(frame_done), 32'd1);
        check_output("ck1_chk_err", 32'(chk_err), 32'd0);
        step();
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000FFFF);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF0000);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h00000000);
        check_output("ck2_chk_err", 32'(chk_err), 32'd1);
        check_output("ck2_words", 32'(words_rcvd), 32'd2);
        step();
        check_output("ck2_done", 32'(frame_done), 32'd1);
        step();
`else
        $display("[TB] basic 3-word frame");
        frame_len      = 8'd3;
        timeout_cycles = 16'd100;
        bus_if.m_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t1_busy", 32'(busy), 32'd1);
        check_output("t1_tok_clr", 32'(bus_if.tok_clr), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hA5A5A5A5);
        check_output("t1_valid0", 32'(bus_if.m_valid), 32'd1);
        check_output("t1_data0", bus_if.m_data, 32'hA5A5A5A5);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h12345678);
        check_output("t1_data1", bus_if.m_data, 32'h12345678);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        check_output("t1_data2", bus_if.m_data, 32'hDEADBEEF);
        check_output("t1_words", 32'(words_rcvd), 32'd3);
        check_output("t1_tok_clr_flush", 32'(bus_if.tok_clr), 32'd1);
        step();
        check_output("t1_drained", 32'(bus_if.m_valid), 32'd0);
        check_output("t1_no_done_yet", 32'(frame_done), 32'd0);
        step();
        check_output("t1_done", 32'(frame_done), 32'd1);
        step();
        check_output("t1_done_pulse", 32'(frame_done), 32'd0);
        check_output("t1_idle", 32'(busy), 32'd0);

        $display("[TB] overflow frame");
        frame_len      = 8'd8;
        bus_if.m_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 32'h10000000 + 32'(i));
        end
        check_output("t2_overflow", 32'(overflow), 32'd1);
        check_output("t2_words", 32'(words_rcvd), 32'd8);
        check_output("t2_head_held", bus_if.m_data, 32'h10000000);
        bus_if.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_output("t2_drain_valid", 32'(bus_if.m_valid), 32'd1);
            check_output("t2_drain_data", bus_if.m_data, 32'h10000000 + 32'(i));
            step();
        end
        check_output("t2_empty", 32'(bus_if.m_valid), 32'd0);
        check_output("t2_no_done_yet", 32'(frame_done), 32'd0);
        step();
        check_output("t2_done", 32'(frame_done), 32'd1);
        step();

        $display("[TB] watchdog timeout");
        frame_len      = 8'd4;
        timeout_cycles = 16'd20;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t3_overflow_cleared", 32'(overflow), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hCAFE0001);
        check_output("t3_data0", bus_if.m_data, 32'hCAFE0001);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hCAFE0002);
        check_output("t3_data1", bus_if.m_data, 32'hCAFE0002);
        for (int i = 0; i < 19; i++) step();
        check_output("t3_not_yet", 32'(timeout_err), 32'd0);
        step();
        check_output("t3_timeout", 32'(timeout_err), 32'd1);
        check_output("t3_tok_clr", 32'(bus_if.tok_clr), 32'd1);
        step();
        check_output("t3_done", 32'(frame_done), 32'd1);
        check_output("t3_words", 32'(words_rcvd), 32'd2);
        step();

        $display("[TB] abort then restart");
        timeout_cycles = 16'd0;
        bus_if.m_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t4_timeout_cleared", 32'(timeout_err), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hBEEF0001);
        check_output("t4_held", 32'(bus_if.m_valid), 32'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
        check_output("t4_m_valid", 32'(bus_if.m_valid), 32'd0);
        check_output("t4_busy", 32'(busy), 32'd0);
        check_output("t4_tok_clr", 32'(bus_if.tok_clr), 32'd1);
        check_output("t4_no_done", 32'(frame_done), 32'd0);
        step();
        check_output("t4_no_done_later", 32'(frame_done), 32'd0);
        frame_len      = 8'd1;
        timeout_cycles = 16'd100;
        bus_if.m_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h00000042);
        check_output("t4_data", bus_if.m_data, 32'h00000042);
        check_output("t4_words", 32'(words_rcvd), 32'd1);
        step();
        step();
        check_output("t4_done", 32'(frame_done), 32'd1);
        step();

        $display("[TB] ignored starts and reset mid-frame");
        frame_len = 8'd0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t5_len0", 32'(busy), 32'd0);
        frame_len = 8'd3;
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        check_output("t5_abort_wins", 32'(busy), 32'd0);
        frame_len      = 8'd2;
        bus_if.m_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h77770001);
        frame_len = 8'd5;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_output("t5_start_busy_words", 32'(words_rcvd), 32'd1);
        check_output("t5_start_busy_state", 32'(bus_if.tok_clr), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_output("t5_rst_m_valid", 32'(bus_if.m_valid), 32'd0);
        check_output("t5_rst_m_data", bus_if.m_data, 32'd0);
        check_output("t5_rst_busy", 32'(busy), 32'd0);
        check_output("t5_rst_tok_clr", 32'(bus_if.tok_clr), 32'd1);
        check_output("t5_rst_words", 32'(words_rcvd), 32'd0);
        check_output("t5_rst_chk_err", 32'(chk_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hsi_rx_sequencer.md
Name: hsi_rx_sequencer

Overview:
Receive-side controller for the HSI gyro link, sitting between the HSCK/HSDATA word tokenizer and the AXI register/readout logic.
- Arms and clears the tokenizer.
- Counts 32-bit tokens into frames of programmable length.
- Buffers tokens in a small FIFO with a valid/ready output handshake.
- Runs an HSCK-inactivity watchdog and reports frame completion, overflow and timeout status.

Parameters:
FIFO_DEPTH, 4, word FIFO depth; power of 2, minimum 2
LEN_W, 8, width of the frame-length and word counters
TO_W, 16, width of the watchdog counter

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begin a frame
abort  in  1  one-cycle pulse; cancel the frame and discard the FIFO
frame_len  in  LEN_W  data words per frame; sampled at start
timeout_cycles  in  TO_W  watchdog limit in clocks; 0 disables the watchdog
tok_valid  in  1  one-cycle pulse from the tokenizer: word complete
tok_data  in  32  tokenizer word; valid with tok_valid
tok_clr  out  1  high holds the tokenizer shift register cleared
m_data  out  32  FIFO head word
m_valid  out  1  m_data valid
m_ready  in  1  consumer accepts the word when m_valid & m_ready
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at frame end (normal or timeout)
words_rcvd  out  LEN_W  tokens accepted in the current/last frame
overflow  out  1  sticky; a token was dropped because the FIFO was full
timeout_err  out  1  sticky; watchdog expired
chk_err  out  1  sticky; checksum mismatch (see Optional Feature)

Behaviour:
- Reset values: tok_clr=1, m_valid=0, m_data=0, busy=0, frame_done=0, words_rcvd=0, overflow=0, timeout_err=0, chk_err=0.
- Reset effects: FIFO empty, state=IDLE.
- FSM states: IDLE, RECV, FLUSH, DONE.
- IDLE:
  - tok_clr=1; tok_valid is ignored.
  - start with frame_len!=0: latch frame_len; clear words_rcvd, overflow, timeout_err and chk_err; clear the watchdog; go to RECV.
  - start with frame_len==0: ignored.
- RECV:
  - tok_clr=0.
  - Each tok_valid: words_rcvd+1; push tok_data into the FIFO; clear the watchdog.
  - When words_rcvd reaches frame_len (on the accepting cycle), go to FLUSH.
  - Otherwise the watchdog increments every cycle without tok_valid. When it equals timeout_cycles (nonzero), set timeout_err and go to FLUSH.
- FLUSH:
  - tok_clr=1; tok_valid is ignored.
  - Remain until the FIFO is empty, then go to DONE.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- abort, in any state: FIFO emptied and m_valid=0 next cycle; go directly to IDLE; no frame_done; sticky flags retained.
- start while busy: ignored. abort and start in the same cycle: abort wins.
- FIFO behaviour:
  - Registered output; tok_valid to m_valid latency is 1 clock when the FIFO is empty.
  - m_data is held stable while m_valid & !m_ready.
  - Push on full with no pop in the same cycle: word dropped, overflow set, word still counted in words_rcvd.
  - Push and pop in the same cycle on full: legal, no overflow.
  - Push and pop in the same cycle on empty: word appears the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; a count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- Watchdog saturates at its limit and does not wrap. With timeout_cycles=0 the watchdog never fires.
- Reset asserted mid-frame returns every output to its reset value on the next clock edge.

Optional Feature:
Macro HSI_RX_SEQ_CHECKSUM_EN.
- Defined:
  - Each frame carries frame_len data words followed by one checksum word.
  - The checksum word is not pushed to the FIFO and not counted in words_rcvd.
  - It is compared with the XOR of all data words in the frame; a mismatch sets chk_err.
  - FLUSH is entered after the checksum word is accepted.
  - A timeout before the checksum arrives sets timeout_err only.
- Not defined: frames are frame_len words; chk_err is tied to 0.

Test Plan:
- frame_len=3, timeout_cycles=100, m_ready=1, tokens A5A5A5A5, 12345678, DEADBEEF -> m_data sequence in that order, each 1 clock after its tok_valid; words_rcvd=3; frame_done one pulse; tok_clr returns to 1.
- frame_len=8, m_ready=0, FIFO_DEPTH=4, 8 tokens -> first 4 words held; overflow=1; words_rcvd=8. Then m_ready=1 -> exactly 4 words drain, then frame_done.
- frame_len=4, timeout_cycles=20, 2 tokens then silence -> timeout_err=1 exactly 20 clocks after the 2nd token; 2 words delivered; frame_done pulses; words_rcvd=2.
- Mid-frame abort after 1 token with m_ready=0 -> next clock: m_valid=0, busy=0, tok_clr=1, no frame_done. A subsequent start with frame_len=1 and one token -> normal completion; sticky flags cleared at start.
- start with frame_len=0 -> busy stays 0. start pulsed while in RECV -> no effect. reset asserted in RECV -> all outputs at reset values next clock.
- With HSI_RX_SEQ_CHECKSUM_EN, frame_len=2, tokens 0000FFFF, FFFF0000:
  - checksum word FFFFFFFF -> chk_err=0, 2 words output.
  - checksum word 00000000 -> chk_err=1.
